rrg_cmd_sequencer: RTL

Command sequencer and two-port arbiter for the realtime ramp generator's (RRG) register interface. Each requester submits a complete ramp parameter set: Yset, Rset, RIset and ROset (64-bit each), a dataset index, and an optional switch flag. The block arbitrates round-robin between two requesters and replays the accepted set as a timed sequence on the RRG command bus (reg_control, reg_0..reg_3). The sequence is: write each value, commit it to the dataset, optionally switch to that dataset, then return to the idle command. Software no longer hand-issues individual commands.

---
 rtl/rrg_cmd_sequencer_if.sv | 52 +++++
 rtl/rrg_cmd_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/rrg_cmd_sequencer_if.sv
// Request and command-bus bundle for the RRG command sequencer.
// The sequencer is the slave: it takes two requesters' parameter sets and
// drives the RRG register command bus plus status pulses.
interface rrg_cmd_sequencer_if;
    logic               req0_valid;
    logic               req0_ready;
    logic [7:0]         req0_dataset;
    logic               req0_switch;
    logic signed [63:0] req0_yset;
    logic signed [63:0] req0_rset;
    logic signed [63:0] req0_riset;
    logic signed [63:0] req0_roset;

    logic               req1_valid;
    logic               req1_ready;
    logic [7:0]         req1_dataset;
    logic               req1_switch;
    logic signed [63:0] req1_yset;
    logic signed [63:0] req1_rset;
    logic signed [63:0] req1_riset;
    logic signed [63:0] req1_roset;

    logic [15:0]        reg_control;
    logic [15:0]        reg_0;
    logic [15:0]        reg_1;
    logic [15:0]        reg_2;
    logic [15:0]        reg_3;
    logic               busy;
    logic               done;
    logic               err;
    logic               resp_id;

    modport master (
        output req0_valid, req0_dataset, req0_switch,
               req0_yset, req0_rset, req0_riset, req0_roset,
        output req1_valid, req1_dataset, req1_switch,
               req1_yset, req1_rset, req1_riset, req1_roset,
        input  req0_ready, req1_ready,
        input  reg_control, reg_0, reg_1, reg_2, reg_3,
        input  busy, done, err, resp_id
    );

    modport slave (
        input  req0_valid, req0_dataset, req0_switch,
               req0_yset, req0_rset, req0_riset, req0_roset,
        input  req1_valid, req1_dataset, req1_switch,
               req1_yset, req1_rset, req1_riset, req1_roset,
        output req0_ready, req1_ready,
        output reg_control, reg_0, reg_1, reg_2, reg_3,
        output busy, done, err, resp_id
    );
endinterface

// File: rtl/rrg_cmd_sequencer.sv
// RRG command sequencer: round-robin arbitration between two requesters,
// then replay of the accepted ramp parameter set as timed command words
// (write Y/R/RI/RO, commit, optional dataset switch, idle gap).
module rrg_cmd_sequencer #(
    parameter int HOLD_CYCLES = 2,
    parameter int NR_DATASETS = 2
) (
    input logic                clk,
    input logic                nReset,
    rrg_cmd_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR_Y, S_WR_R, S_WR_RI, S_WR_RO, S_UPD, S_SW, S_GAP
    } state_t;

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   hold_cnt;
    logic               last_grant;
    logic               grant0;
    logic               accept;
    logic               acc_id;
    logic               acc_ds_ok;
    logic [7:0]         acc_ds;
    logic               acc_sw;
    logic signed [63:0] acc_y, acc_r, acc_ri, acc_ro;
    logic [7:0]         ds_q;
    logic               sw_q;
    logic signed [63:0] y_q, r_q, ri_q, ro_q;

    // Command word {reg_control, reg_3, reg_2, reg_1, reg_0} shown in state s.
    function automatic logic [79:0] bus_word(input state_t s, input logic [7:0] ds,
                                             input logic signed [63:0] y, r, ri, ro);
        logic [7:0]  code;
        logic [63:0] val;
        code = 8'd0;
        val  = 64'd0;
        case (s)
            S_WR_Y:  begin code = 8'd1; val = y;  end
            S_WR_R:  begin code = 8'd2; val = r;  end
            S_WR_RI: begin code = 8'd3; val = ri; end
            S_WR_RO: begin code = 8'd4; val = ro; end
            S_UPD:   code = 8'd5;
            S_SW:    code = 8'd6;
            default: code = 8'd0;
        endcase
        return (code == 8'd0) ? 80'd0 : {ds, code, val};
    endfunction

    // Successor of a sequencing state once its hold time has elapsed.
    function automatic state_t succ(input state_t s, input logic sw);
        case (s)
            S_WR_Y:  return S_WR_R;
            S_WR_R:  return S_WR_RI;
            S_WR_RI: return S_WR_RO;
            S_WR_RO: return S_UPD;
            S_UPD:   return sw ? S_SW : S_GAP;
            S_SW:    return S_GAP;
            default: return S_IDLE;
        endcase
    endfunction

    // req0 wins unless req1 is also pending and req0 was served last.
    assign grant0         = !bus.req1_valid || last_grant;
    assign bus.req0_ready = (state == S_IDLE) && bus.req0_valid && grant0;
    assign bus.req1_ready = (state == S_IDLE) && bus.req1_valid && !grant0;
    assign accept         = bus.req0_ready || bus.req1_ready;
    assign acc_id         = bus.req1_ready;
    assign acc_ds_ok      = int'(acc_ds) < NR_DATASETS;
    assign state_nxt      = succ(state, sw_q);

    // Payload of whichever requester is being accepted this cycle.
    always_comb begin
        acc_ds = acc_id ? bus.req1_dataset : bus.req0_dataset;
        acc_sw = acc_id ? bus.req1_switch  : bus.req0_switch;
        acc_y  = acc_id ? bus.req1_yset    : bus.req0_yset;
        acc_r  = acc_id ? bus.req1_rset    : bus.req0_rset;
        acc_ri = acc_id ? bus.req1_riset   : bus.req0_riset;
        acc_ro = acc_id ? bus.req1_roset   : bus.req0_roset;
    end

    // Capture the accepted parameter set; pure data, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            ds_q <= acc_ds;
            sw_q <= acc_sw;
            y_q  <= acc_y;
            r_q  <= acc_r;
            ri_q <= acc_ri;
            ro_q <= acc_ro;
        end
    end

    // Sequencer FSM with registered bus word, status pulses and hold timer.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state       <= S_IDLE;
            hold_cnt    <= '0;
            last_grant  <= 1'b1;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
            bus.resp_id <= 1'b0;
            {bus.reg_control, bus.reg_3, bus.reg_2, bus.reg_1, bus.reg_0} <= 80'd0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            if (state == S_IDLE) begin
                if (accept) begin
                    last_grant  <= acc_id;
                    bus.resp_id <= acc_id;
                    if (acc_ds_ok) begin
                        state    <= S_WR_Y;
                        hold_cnt <= HOLD_LAST;
                        bus.busy <= 1'b1;
                        {bus.reg_control, bus.reg_3, bus.reg_2, bus.reg_1, bus.reg_0} <=
                            bus_word(S_WR_Y, acc_ds, acc_y, acc_r, acc_ri, acc_ro);
                    end else begin
                        bus.err <= 1'b1;
                    end
                end
            end else if (hold_cnt == '0) begin
                state    <= state_nxt;
                hold_cnt <= HOLD_LAST;
                {bus.reg_control, bus.reg_3, bus.reg_2, bus.reg_1, bus.reg_0} <=
                    bus_word(state_nxt, ds_q, y_q, r_q, ri_q, ro_q);
                if (state_nxt == S_IDLE) begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                end
            end else begin
                hold_cnt <= hold_cnt - CNT_W'(1);
            end
        end
    end
endmodule
